// File: rtl/fir_tap_sum.sv
// Downstream stage of the 3-tap FIR: pipelined tap-product sum, round half-up,
// saturate to DATAWIDTH, with a valid/ready whole-pipeline stall and a saturation counter.
module fir_tap_sum #(
    parameter int unsigned DATAWIDTH     = 16,
    parameter int unsigned PRODUCT_WIDTH = 2 * DATAWIDTH,
    parameter int unsigned FRAC_BITS     = 15,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [PRODUCT_WIDTH-1:0] tin_tap0,
    input  logic signed [PRODUCT_WIDTH-1:0] tin_tap1,
    input  logic signed [PRODUCT_WIDTH-1:0] tin_tap2,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic signed [DATAWIDTH-1:0]     out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            sat_clr,
    output logic [CNT_WIDTH-1:0]            sat_count,
    output logic                            sat_flag
);

    localparam int unsigned S1W = PRODUCT_WIDTH + 1;
    localparam int unsigned S2W = PRODUCT_WIDTH + 2;
    // One extra bit so adding the rounding constant can never wrap.
    localparam int unsigned RW  = PRODUCT_WIDTH + 3;

    localparam logic signed [RW-1:0] HALF    = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAX_POS = RW'({1'b0, {(DATAWIDTH-1){1'b1}}});
    localparam logic signed [RW-1:0] MIN_NEG = ~MAX_POS;

    logic                  en;
    logic signed [S1W-1:0] s1_a;
    logic signed [S1W-1:0] s1_b;
    logic                  v1;
    logic signed [S2W-1:0] s2_sum;
    logic                  v2;

    logic signed [RW-1:0]        rnd_c;
    logic signed [RW-1:0]        r_c;
    logic signed [DATAWIDTH-1:0] sat_data_c;
    logic                        sat_hit_c;

    // Whole pipeline advances only when the output slot is free or being drained.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Round half toward +inf, then clamp into the output range.
    always_comb begin
        rnd_c      = RW'(s2_sum) + HALF;
        r_c        = rnd_c >>> FRAC_BITS;
        sat_hit_c  = 1'b0;
        sat_data_c = r_c[DATAWIDTH-1:0];
        if (r_c > MAX_POS) begin
            sat_data_c = MAX_POS[DATAWIDTH-1:0];
            sat_hit_c  = 1'b1;
        end else if (r_c < MIN_NEG) begin
            sat_data_c = MIN_NEG[DATAWIDTH-1:0];
            sat_hit_c  = 1'b1;
        end
    end

    // Data registers load only behind a valid bit; bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a      <= '0;
            s1_b      <= '0;
            v1        <= 1'b0;
            s2_sum    <= '0;
            v2        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                s1_a <= S1W'(tin_tap0) + S1W'(tin_tap1);
                s1_b <= S1W'(tin_tap2);
            end
            if (v1) begin
                s2_sum <= S2W'(s1_a) + S2W'(s1_b);
            end
            if (v2) begin
                out_data <= sat_data_c;
            end
        end
    end

    // Saturation event counter; a coincident clear wins, and the count pins at all-ones.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_count <= '0;
            sat_flag  <= 1'b0;
        end else if (en && v2 && sat_hit_c) begin
            sat_flag <= 1'b1;
            if (sat_count != {CNT_WIDTH{1'b1}}) begin
                sat_count <= sat_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sum.sv
// Bench for fir_tap_sum: directed and random traffic scored against an arithmetic
// reference model; a second instance with a 2-bit counter covers the counter ceiling.
module tb_fir_tap_sum;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tap0, tap1, tap2;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic        sat_clr;
    logic [7:0]  sat_count;
    logic        sat_flag;

    logic [31:0] b_tap;
    logic        b_in_valid, b_in_ready;
    logic [15:0] b_out_data;
    logic        b_out_valid, b_out_ready;
    logic [1:0]  b_sat_count;
    logic        b_sat_flag;

    always #5 clk = ~clk;

    fir_tap_sum dut (
        .clk(clk), .rst(rst),
        .tin_tap0(tap0), .tin_tap1(tap1), .tin_tap2(tap2),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_clr(sat_clr), .sat_count(sat_count), .sat_flag(sat_flag)
    );

    fir_tap_sum #(.CNT_WIDTH(2)) dut_cnt2 (
        .clk(clk), .rst(rst),
        .tin_tap0(b_tap), .tin_tap1(b_tap), .tin_tap2(b_tap),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sat_clr(1'b0), .sat_count(b_sat_count), .sat_flag(b_sat_flag)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          nsat = 0;
    int          n_pop = 0;
    logic [15:0] last_out = '0;
    bit          held_valid = 0;
    logic [15:0] held_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact sum, floor((s + 0.5 LSB) / 2^15), clamp to int16.
    function automatic logic [15:0] ref_sample(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, output bit sat);
        longint s, r;
        s   = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c));
        r   = (s + 64'sd16384) >>> 15;
        sat = 1'b1;
        if (r > 64'sd32767) return 16'h7fff;
        if (r < -64'sd32768) return 16'h8000;
        sat = 1'b0;
        return 16'(r);
    endfunction

    function automatic logic [31:0] rnd_tap();
        if ($urandom_range(0, 1) == 1) return $urandom();
        return 32'($urandom_range(0, 2097152)) - 32'd1048576;
    endfunction

    // One clock: sample the settled handshake, score the output, model acceptance.
    task automatic tick();
        bit s;
        #1;
        if (rst) begin
            held_valid = 0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (held_valid) check("stall_hold", 32'(out_data), 32'(held_data));
                if (out_ready) begin
                    if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
                    else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    last_out = out_data;
                    n_pop++;
                    held_valid = 0;
                end else begin
                    held_valid = 1;
                    held_data  = out_data;
                end
            end else if (held_valid) begin
                check("stall_valid_drop", 32'(out_valid), 32'd1);
                held_valid = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sample(tap0, tap1, tap2, s));
                if (s) nsat++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 0;
        out_ready = 1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        tap0 = a; tap1 = b; tap2 = c;
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_sat_count"}, 32'(sat_count), 32'd0);
        check({tag, "_sat_flag"},  32'(sat_flag),  32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pat;
        logic [31:0] rnd_vals [4];
        logic [15:0] rnd_exp  [4];
        int idx, stall, cyc;
        bit first_seen;

        rst = 1; sat_clr = 0; in_valid = 0; out_ready = 1;
        tap0 = '0; tap1 = '0; tap2 = '0;
        b_tap = '0; b_in_valid = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_idle_reset("reset");

        // Back-to-back: 4 samples give 4 consecutive outputs, third edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            tap0 = 32'h1000_0000; tap1 = 32'h1000_0000; tap2 = 32'h1000_0000;
            in_valid = (i < 4);
            tick();
            pat[i] = out_valid;
        end
        check("b2b_pattern", 32'(pat), 32'h3c);
        drain();
        check("nominal_value", 32'(last_out), 32'h6000);

        rnd_vals = '{32'h0000_4000, 32'h0000_3fff, 32'hffff_c000, 32'hffff_bfff};
        rnd_exp  = '{16'h0001, 16'h0000, 16'h0000, 16'hffff};
        for (int i = 0; i < 4; i++) begin
            send3(rnd_vals[i], 32'd0, 32'd0);
            drain();
            check($sformatf("round_%0d", i), 32'(last_out), 32'(rnd_exp[i]));
        end

        send3(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        drain();
        check("sat_pos_value", 32'(last_out), 32'h7fff);
        check("sat_pos_count", 32'(sat_count), 32'd1);
        check("sat_pos_flag",  32'(sat_flag),  32'd1);
        send3(32'hc000_0000, 32'hc000_0000, 32'hc000_0000);
        drain();
        check("sat_neg_value", 32'(last_out), 32'h8000);
        check("sat_neg_count", 32'(sat_count), 32'd2);

        // Clear lands on the edge where S3 loads the saturated sample.
        send3(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        tick();
        sat_clr = 1;
        tick();
        sat_clr = 0;
        nsat = 0;
        drain();
        check("clr_win_count", 32'(sat_count), 32'd0);
        check("clr_win_flag",  32'(sat_flag),  32'd0);
        check("clr_win_value", 32'(last_out), 32'h7fff);

        // Backpressure: 6 samples, out_ready low for 5 cycles after first out_valid.
        idx = 0; stall = 0; first_seen = 0; cyc = 0;
        n_pop = 0;
        while ((idx < 6 || exp_q.size() != 0 || out_valid) && cyc < 60) begin
            tap0 = 32'(idx + 1) << 16; tap1 = 32'(idx) << 12; tap2 = 32'hffff_0000;
            in_valid = (idx < 6);
            if (out_valid) first_seen = 1;
            out_ready = !(first_seen && stall < 5);
            if (!out_ready) stall++;
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        drain();
        check("bp_stall_cycles", 32'(stall), 32'd5);
        check("bp_pop_count", 32'(n_pop), 32'd6);

        for (int i = 0; i < 300; i++) begin
            tap0 = rnd_tap(); tap1 = rnd_tap(); tap2 = rnd_tap();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("rand_sat_count", 32'(sat_count), 32'((nsat > 255) ? 255 : nsat));
        check("rand_sat_flag",  32'(sat_flag),  32'(nsat != 0));

        // Reset mid-stream discards in-flight samples.
        send3(32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        drain();
        for (int i = 0; i < 3; i++) begin
            tap0 = rnd_tap(); tap1 = rnd_tap(); tap2 = rnd_tap();
            in_valid = 1;
            tick();
        end
        rst = 1;
        tick();
        tick();
        check_idle_reset("midrst");
        exp_q.delete();
        nsat = 0;
        rst = 0;
        tap0 = rnd_tap();
        repeat (6) tick();
        in_valid = 0;
        repeat (4) tick();
        check("midrst_no_stale", 32'(out_valid), 32'd0);

        // 2-bit counter instance: 5 saturations pin at 3.
        b_tap = 32'h4000_0000;
        b_in_valid = 1;
        check("cnt2_in_ready", 32'(b_in_ready), 32'd1);
        repeat (5) tick();
        b_in_valid = 0;
        repeat (5) tick();
        check("cnt2_ceiling", 32'(b_sat_count), 32'd3);
        check("cnt2_flag",    32'(b_sat_flag),  32'd1);
        check("cnt2_value",   32'(b_out_data),  32'h7fff);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_tap_sum.md
Name: fir_tap_sum

Overview:
- Downstream stage of the 3-tap FIR delay/product registers.
- Consumes the three signed tap products (PRODUCT_WIDTH each), sums them in a 3-stage pipeline, rounds and saturates the sum to DATAWIDTH, and presents one filtered output sample per accepted input.
- Uses a valid/ready handshake with whole-pipeline stall, and keeps a saturation event counter for debug.

Parameters:
- DATAWIDTH, 16, width of the output sample. Matches the FIR sample width.
- PRODUCT_WIDTH, 2*DATAWIDTH, width of each tap product input.
- FRAC_BITS, 15, right-shift applied after summation; Q15×Q15 products give a Q15 result.
- CNT_WIDTH, 8, width of the saturation event counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tin_tap0  in  PRODUCT_WIDTH  signed tap-0 product.
- tin_tap1  in  PRODUCT_WIDTH  signed tap-1 product.
- tin_tap2  in  PRODUCT_WIDTH  signed tap-2 product.
- in_valid  in  1  tap products valid this cycle.
- in_ready  out  1  stage accepts inputs this cycle.
- out_data  out  DATAWIDTH  signed rounded/saturated filter output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- sat_clr  in  1  clears sat_count and sat_flag.
- sat_count  out  CNT_WIDTH  number of saturated outputs; sticks at all-ones.
- sat_flag  out  1  sticky: at least one saturation since reset/clear.

Behaviour:
- Reset: one clock and synchronous active-high reset (rst) as decided; only clk/rst are sampled for reset.
  - All pipeline registers and valid bits are cleared; out_data=0, out_valid=0, sat_count=0, sat_flag=0.
  - in_ready=1 from the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight samples; nothing partial is emitted.
- Advance enable: en = !out_valid || out_ready. Purely combinational.
  - in_ready = en.
  - When en=0, every pipeline stage, including the valid bits, holds.
- An input is accepted when in_valid && in_ready.
- S1 (on en): s1_a = tap0 + tap1, sign-extended to PRODUCT_WIDTH+1; s1_b = tap2 sign-extended; v1 = in_valid.
- S2 (on en): s2_sum = s1_a + s1_b, sign-extended to PRODUCT_WIDTH+2. The sum is exact and cannot overflow. v2 = v1.
- S3 (on en): r = (s2_sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half toward +inf.
  - If r > 2^(DATAWIDTH-1)-1, out_data = max positive. If r < -2^(DATAWIDTH-1), out_data = min negative. Otherwise out_data = r[DATAWIDTH-1:0].
  - out_valid = v2.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput is 1 sample/cycle.
- Bubbles (v=0) propagate. Bubble stages never touch sat_count.
- Output held stable: while out_valid=1 && out_ready=0, out_data must not change.
- Saturation count:
  - sat_count increments by 1 when S3 loads a valid saturated result on en.
  - It holds at 2^CNT_WIDTH-1 and does not wrap.
  - sat_flag sets on the same event.
- sat_clr: synchronous. It clears sat_count and sat_flag. If sat_clr coincides with a saturation event, clear wins and the result is 0.
- Inputs are not sampled when in_valid=0. Tap product values on those cycles are don't-care.

Test Plan:
- Reset/idle: assert rst 2 cycles mid-stream with in_valid=1 → out_valid=0, out_data=0, sat_count=0, in_ready=1; no stale sample emitted after release.
- Nominal sum: taps 0x10000000 ×3, out_ready=1 → out_data=0x6000 (24576) exactly 3 cycles later; back-to-back 4 inputs give 4 consecutive valid outputs.
- Rounding: sum 0x00004000 (tap0=0x4000, others 0) → out_data=1; sum 0x00003FFF → 0; sum 0xFFFFC000 (tap0=-16384) → 0; sum tap0=0xFFFFBFFF → -1 (0xFFFF).
- Saturation: taps 0x40000000 ×3 → 0x7FFF, sat_count=1, sat_flag=1; taps 0xC0000000 ×3 → 0x8000, sat_count=2. Then sat_clr coincident with a third saturating sample → sat_count=0, sat_flag=0.
- Backpressure: stream 6 samples, hold out_ready=0 for 5 cycles after first out_valid → in_ready=0 throughout the stall, out_data stable, no sample lost or duplicated; after release, outputs appear in order.
- Counter ceiling (CNT_WIDTH=2 build): 5 saturating samples → sat_count sticks at 3.
